cache_request_arbiter: RTL and testbench

- Sits directly upstream of the shared cache; the two final_project CPUs feed it.
- Buffers each CPU's 22-bit cache requests in its own small FIFO and arbitrates round-robin between the two FIFOs.
- Issues one request at a time to the cache, honouring the cache's busy signal.
- Replaces direct per-CPU drive of the cache request lines, so neither CPU has to poll cache_busy itself.

---
 rtl/cache_request_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_cache_request_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_request_arbiter.sv
// cache_request_arbiter
// Two per-CPU request FIFOs feeding the shared cache through a round-robin
// arbiter. One request is issued at a time as a single-cycle valid pulse,
// and the arbiter waits for the cache to drop cache_busy before the next.
// Optional build macro: ARB_TRISTATE_IDLE_EN -- when defined, cache_request
// floats (all-Z) whenever cache_req_valid is low; otherwise it reads zero.
module cache_request_arbiter #(
    parameter int REQ_W      = 22,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             p0_req_valid,
    input  logic [REQ_W-1:0] p0_request,
    output logic             p0_req_ready,
    input  logic             p1_req_valid,
    input  logic [REQ_W-1:0] p1_request,
    output logic             p1_req_ready,
    input  logic             cache_busy,
    output logic             cache_req_valid,
    output logic [REQ_W-1:0] cache_request,
    output logic             grant_id,
    output logic [CNT_W-1:0] p0_count,
    output logic [CNT_W-1:0] p1_count
);

    localparam int               PTR_W    = CNT_W - 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    // CPU0 FIFO
    logic [REQ_W-1:0] r_p0_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_p0_wptr;
    logic [PTR_W-1:0] r_p0_rptr;
    logic [CNT_W-1:0] r_p0_cnt;
    logic [REQ_W-1:0] w_p0_word;
    logic             w_p0_push;
    logic             w_p0_pop;
    logic             w_p0_empty;
    logic             w_p0_full;

    // CPU1 FIFO
    logic [REQ_W-1:0] r_p1_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_p1_wptr;
    logic [PTR_W-1:0] r_p1_rptr;
    logic [CNT_W-1:0] r_p1_cnt;
    logic [REQ_W-1:0] w_p1_word;
    logic             w_p1_push;
    logic             w_p1_pop;
    logic             w_p1_empty;
    logic             w_p1_full;

    // Arbitration / output
    logic             w_take;
    logic             w_sel;
    logic [REQ_W-1:0] r_out_req;
    logic             r_grant;
    logic             r_last_grant;

    assign w_p0_empty = (r_p0_cnt == '0);
    assign w_p1_empty = (r_p1_cnt == '0);
    assign w_p0_full  = (r_p0_cnt == FULL_CNT);
    assign w_p1_full  = (r_p1_cnt == FULL_CNT);

    // A full FIFO refuses pushes even when it is being popped the same cycle.
    assign w_p0_push = p0_req_valid && !w_p0_full;
    assign w_p1_push = p1_req_valid && !w_p1_full;

    // Stored words carry the port index in the proc_id bit, whatever the CPU drove.
    always_comb begin
        w_p0_word            = p0_request;
        w_p0_word[REQ_W-1]   = 1'b0;
        w_p1_word            = p1_request;
        w_p1_word[REQ_W-1]   = 1'b1;
    end

    // CPU0 FIFO storage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                r_p0_mem[i] <= '0;
            end
        end else if (w_p0_push) begin
            r_p0_mem[r_p0_wptr] <= w_p0_word;
        end
    end

    // CPU0 FIFO pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_p0_wptr <= '0;
            r_p0_rptr <= '0;
            r_p0_cnt  <= '0;
        end else begin
            if (w_p0_push) begin
                r_p0_wptr <= r_p0_wptr + 1'b1;
            end
            if (w_p0_pop) begin
                r_p0_rptr <= r_p0_rptr + 1'b1;
            end
            case ({w_p0_push, w_p0_pop})
                2'b10:   r_p0_cnt <= r_p0_cnt + 1'b1;
                2'b01:   r_p0_cnt <= r_p0_cnt - 1'b1;
                default: r_p0_cnt <= r_p0_cnt;
            endcase
        end
    end

    // CPU1 FIFO storage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                r_p1_mem[i] <= '0;
            end
        end else if (w_p1_push) begin
            r_p1_mem[r_p1_wptr] <= w_p1_word;
        end
    end

    // CPU1 FIFO pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_p1_wptr <= '0;
            r_p1_rptr <= '0;
            r_p1_cnt  <= '0;
        end else begin
            if (w_p1_push) begin
                r_p1_wptr <= r_p1_wptr + 1'b1;
            end
            if (w_p1_pop) begin
                r_p1_rptr <= r_p1_rptr + 1'b1;
            end
            case ({w_p1_push, w_p1_pop})
                2'b10:   r_p1_cnt <= r_p1_cnt + 1'b1;
                2'b01:   r_p1_cnt <= r_p1_cnt - 1'b1;
                default: r_p1_cnt <= r_p1_cnt;
            endcase
        end
    end

    // Round-robin pick: lone non-empty port wins; on contention the port
    // that did not win last time goes.
    always_comb begin
        w_sel = 1'b0;
        if (!w_p0_empty && !w_p1_empty) begin
            w_sel = ~r_last_grant;
        end else if (w_p0_empty) begin
            w_sel = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and pop decode
    always_comb begin
        w_next   = r_state;
        w_take   = 1'b0;
        w_p0_pop = 1'b0;
        w_p1_pop = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!cache_busy && (!w_p0_empty || !w_p1_empty)) begin
                    w_take   = 1'b1;
                    w_p0_pop = ~w_sel;
                    w_p1_pop = w_sel;
                    w_next   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_next = S_HOLD;
            end
            S_HOLD: begin
                if (!cache_busy) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Capture the popped head and record which port was served
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_req    <= '0;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (w_take) begin
            r_out_req    <= w_sel ? r_p1_mem[r_p1_rptr] : r_p0_mem[r_p0_rptr];
            r_grant      <= w_sel;
            r_last_grant <= w_sel;
        end
    end

    assign cache_req_valid = (r_state == S_ISSUE);
    assign grant_id        = r_grant;
    assign p0_req_ready    = !w_p0_full;
    assign p1_req_ready    = !w_p1_full;
    assign p0_count        = r_p0_cnt;
    assign p1_count        = r_p1_cnt;

`ifdef ARB_TRISTATE_IDLE_EN
    assign cache_request = cache_req_valid ? r_out_req : {REQ_W{1'bz}};
`else
    assign cache_request = cache_req_valid ? r_out_req : '0;
`endif

endmodule

// File: tb/tb_cache_request_arbiter.sv
// tb_cache_request_arbiter
// Directed stimulus; expected cache requests are queued as stimulus is
// issued and a negedge monitor pops and compares on every cache_req_valid.
module tb_cache_request_arbiter;

    logic        clk;
    logic        reset;
    logic        p0_req_valid;
    logic [21:0] p0_request;
    logic        p0_req_ready;
    logic        p1_req_valid;
    logic [21:0] p1_request;
    logic        p1_req_ready;
    logic        cache_busy;
    logic        cache_req_valid;
    logic [21:0] cache_request;
    logic        grant_id;
    logic [2:0]  p0_count;
    logic [2:0]  p1_count;

    int          n_vec;
    int          n_fail;
    int          cyc;
    logic [21:0] exp_q[$];
    int          issue_cyc[$];

`ifdef ARB_TRISTATE_IDLE_EN
    localparam logic [21:0] IDLE_VAL = {22{1'bz}};
`else
    localparam logic [21:0] IDLE_VAL = 22'd0;
`endif
    localparam logic [21:0] P1_BIT = 22'h200000;

    cache_request_arbiter #(
        .REQ_W      (22),
        .FIFO_DEPTH (4),
        .CNT_W      (3)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .p0_req_valid    (p0_req_valid),
        .p0_request      (p0_request),
        .p0_req_ready    (p0_req_ready),
        .p1_req_valid    (p1_req_valid),
        .p1_request      (p1_request),
        .p1_req_ready    (p1_req_ready),
        .cache_busy      (cache_busy),
        .cache_req_valid (cache_req_valid),
        .cache_request   (cache_request),
        .grant_id        (grant_id),
        .p0_count        (p0_count),
        .p1_count        (p1_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [21:0] act, input logic [21:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (cache_req_valid === 1'b1) begin
            issue_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_issue: got %h expected no issue (t=%0t)", cache_request, $time);
            end else begin
                logic [21:0] e;
                e = exp_q.pop_front();
                chk("issue_word", cache_request, e);
                chk("issue_grant", 22'(grant_id), 22'(e[21]));
            end
        end else begin
            chk("idle_value", cache_request, IDLE_VAL);
        end
    end

    task automatic drive(input logic v0, input logic [21:0] d0, input logic v1, input logic [21:0] d1);
        p0_req_valid = v0;
        p0_request   = d0;
        p1_req_valid = v1;
        p1_request   = d1;
        @(posedge clk);
        #1;
        p0_req_valid = 1'b0;
        p1_req_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [21:0] w1, w2, w5a, w5b, w7a, w7b;
        logic [21:0] w3[4];
        logic [21:0] w4[5];
        logic [21:0] w6[4];

        n_vec = 0; n_fail = 0; cyc = 0;
        reset = 1'b1; cache_busy = 1'b0;
        p0_req_valid = 1'b0; p0_request = '0;
        p1_req_valid = 1'b0; p1_request = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid",    22'(cache_req_valid), 22'd0);
        chk("rst_p0_ready", 22'(p0_req_ready), 22'd1);
        chk("rst_p1_ready", 22'(p1_req_ready), 22'd1);
        chk("rst_p0_count", 22'(p0_count), 22'd0);
        chk("rst_p1_count", 22'(p1_count), 22'd0);
        chk("rst_grant",    22'(grant_id), 22'd0);
        chk("rst_request",  cache_request, IDLE_VAL);
        @(posedge clk); #1;
        reset = 1'b0;

        // 1: two-cycle latency into an empty, idle arbiter
        w1 = 22'b0_0_01011010000_0_00000000;
        exp_q.push_back(w1);
        drive(1'b1, w1, 1'b0, '0);
        @(negedge clk);
        chk("t1_count_mid", 22'(p0_count), 22'd1);
        chk("t1_valid_early", 22'(cache_req_valid), 22'd0);
        @(negedge clk);
        chk("t1_valid", 22'(cache_req_valid), 22'd1);
        chk("t1_count_after", 22'(p0_count), 22'd0);
        drain();

        // 2: CPU1 word gets proc_id forced to 1
        w2 = 22'b0_1_01010000000_1_11111111;
        exp_q.push_back(w2 | P1_BIT);
        drive(1'b0, '0, 1'b1, w2);
        drain();

        // 3: contention alternates P0,P1,P0,P1, one issue per 3 cycles
        w3[0] = 22'h0A5A5; w3[1] = 22'h05555; w3[2] = 22'h01234; w3[3] = 22'h0ABCD;
        exp_q.push_back(w3[0]);
        exp_q.push_back(w3[1] | P1_BIT);
        exp_q.push_back(w3[2]);
        exp_q.push_back(w3[3] | P1_BIT);
        issue_cyc.delete();
        drive(1'b1, w3[0], 1'b1, w3[1]);
        drive(1'b1, w3[2], 1'b1, w3[3]);
        drain();
        chk("t3_issues", 22'(issue_cyc.size()), 22'd4);
        if (issue_cyc.size() == 4) begin
            for (int i = 1; i < 4; i++) begin
                chk("t3_gap", 22'(issue_cyc[i] - issue_cyc[i-1]), 22'd3);
            end
        end

        // 4: full FIFO back-pressure while cache is busy
        w4[0] = 22'h3F0001; w4[1] = 22'h000102; w4[2] = 22'h2AAA03; w4[3] = 22'h155504;
        w4[4] = 22'h0DEAD5;
        cache_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            p0_req_valid = 1'b1;
            p0_request   = w4[i];
            if (i == 4) begin
                chk("t4_ready_full", 22'(p0_req_ready), 22'd0);
                chk("t4_count_full", 22'(p0_count), 22'd4);
            end
            @(posedge clk); #1;
        end
        p0_req_valid = 1'b0;
        chk("t4_count_hold", 22'(p0_count), 22'd4);
        @(negedge clk);
        chk("t4_no_issue_busy", 22'(cache_req_valid), 22'd0);
        for (int i = 0; i < 4; i++) exp_q.push_back(w4[i] & ~P1_BIT);
        @(posedge clk); #1;
        cache_busy = 1'b0;
        drain();
        chk("t4_count_empty", 22'(p0_count), 22'd0);

        // 5: extended busy holds off the next issue
        w5a = 22'h012345; w5b = 22'h054321;
        exp_q.push_back(w5a | P1_BIT);
        exp_q.push_back(w5b);
        p1_req_valid = 1'b1; p1_request = w5a;
        @(posedge clk); #1;
        p1_req_valid = 1'b0;
        @(posedge clk); #1;
        cache_busy = 1'b1;
        p0_req_valid = 1'b1; p0_request = w5b;
        @(posedge clk); #1;
        p0_req_valid = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("t5_busy_no_valid", 22'(cache_req_valid), 22'd0);
        end
        @(posedge clk); #1;
        cache_busy = 1'b0;
        @(negedge clk);
        chk("t5_after_drop", 22'(cache_req_valid), 22'd0);
        drain();

        // 6: reset during HOLD discards queued entries immediately
        w6[0] = 22'h011111; w6[1] = 22'h022222; w6[2] = 22'h033333; w6[3] = 22'h044444;
        cache_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 1'b1, w6[i]);
        end
        chk("t6_count_full", 22'(p1_count), 22'd4);
        exp_q.push_back(w6[0] | P1_BIT);
        cache_busy = 1'b0;
        @(posedge clk); #1;
        cache_busy = 1'b1;
        @(posedge clk); #1;
        chk("t6_count_queued", 22'(p1_count), 22'd3);
        chk("t6_grant_pre", 22'(grant_id), 22'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_p0_count", 22'(p0_count), 22'd0);
        chk("t6_p1_count", 22'(p1_count), 22'd0);
        chk("t6_valid", 22'(cache_req_valid), 22'd0);
        chk("t6_request", cache_request, IDLE_VAL);
        chk("t6_grant", 22'(grant_id), 22'd0);
        chk("t6_p1_ready", 22'(p1_req_ready), 22'd1);
        chk("t6_sb_empty", 22'(exp_q.size()), 22'd0);
        @(posedge clk); #1;
        cache_busy = 1'b0;
        reset = 1'b0;

        // 7: first contention after reset goes to CPU0
        w7a = 22'h0CAFE0; w7b = 22'h0BEEF1;
        exp_q.push_back(w7a);
        exp_q.push_back(w7b | P1_BIT);
        drive(1'b1, w7a, 1'b1, w7b);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
